// File: rtl/icache_pkg.sv
// icache_pkg: address-split widths, FSM encoding and the MMIO match helper
// shared by l1icache_sa and icache_way.
package icache_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t REFILL = 2'd1;
  localparam state_t BYPASS = 2'd2;
  localparam state_t FLUSH  = 2'd3;

  function automatic int unsigned offset_w(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int unsigned index_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned line_bytes,
                                        input int unsigned sets);
    return 32 - offset_w(line_bytes) - index_w(sets);
  endfunction

  function automatic logic is_mmio(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/icache_way.sv
// icache_way: one way of the set-associative I-cache. Valid bits are
// reset flops; tag and data arrays are unreset memories. All reads are
// asynchronous; one line write port and one per-set valid clear port.
module icache_way #(
  parameter int unsigned SETS   = 256,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned TAG_W  = 19,
  parameter int unsigned LINE_W = 256
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   valid_d;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  // Next-state of the valid vector: flush clear, then refill set.
  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_idx] = 1'b0;
    if (wr_en)  valid_d[wr_idx]  = 1'b1;
  end

  // Valid flops, cleared asynchronously.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag/data array write on refill.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/l1icache_sa.sv
// l1icache_sa: set-associative L1 instruction cache between IF and MMU.
// Same-cycle hits, single-line refill over the MMU handshake, uncached
// MMIO bypass, full flush one set per cycle, round-robin replacement.
// Optional performance counters under `ICACHE_PERF_CNT_EN.
module l1icache_sa
  import icache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 256,
  parameter int unsigned LINE_BYTES = 32,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter logic [31:0] MMIO_MASK  = 32'hFFFF_0000
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    l1_read,
  input  logic [31:0]             l1_addr,
  output logic [31:0]             l1_data_o,
  output logic                    stall,
  input  logic                    l1_invalidate,
  output logic                    l1_mmu_req_read,
  output logic [31:0]             l1_mmu_req_addr,
  input  logic                    mmu_l1_done,
  input  logic [LINE_BYTES*8-1:0] mmu_l1_read_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]             perf_hits,
  output logic [31:0]             perf_misses
`endif
);

  localparam int unsigned OFF_W  = offset_w(LINE_BYTES);
  localparam int unsigned IDX_W  = index_w(SETS);
  localparam int unsigned TAG_W  = tag_w(LINE_BYTES, SETS);
  localparam int unsigned WORD_W = OFF_W - 2;
  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Request address split
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              mmio;

  assign req_tag  = l1_addr[31 -: TAG_W];
  assign req_idx  = l1_addr[OFF_W +: IDX_W];
  assign req_word = l1_addr[2 +: WORD_W];
  assign mmio     = is_mmio(l1_addr, MMIO_BASE, MMIO_MASK);

  // State
  state_t                       state_q, state_d;
  logic [31-OFF_W:0]            line_q, line_d;
  logic [WAY_W-1:0]             victim_q, victim_d;
  logic                         pend_q, pend_d;
  logic [IDX_W-1:0]             flush_idx_q, flush_idx_d;
  logic                         req_q, req_d;
  logic [31:0]                  req_addr_q, req_addr_d;
  logic [SETS-1:0][WAY_W-1:0]   rr_q, rr_d;

  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             refill_wr;

  assign fill_idx  = line_q[IDX_W-1:0];
  assign fill_tag  = line_q[IDX_W +: TAG_W];
  assign refill_wr = (state_q == REFILL) && mmu_l1_done;

  // Way array
  logic [WAYS-1:0]   way_valid;
  logic [WAYS-1:0]   way_hit;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_line [WAYS];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS   (SETS),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .LINE_W (LINE_W)
    ) u_way (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .rd_idx   (req_idx),
      .rd_valid (way_valid[w]),
      .rd_tag   (way_tag[w]),
      .rd_line  (way_line[w]),
      .wr_en    (refill_wr && (victim_q == WAY_W'(w))),
      .wr_idx   (fill_idx),
      .wr_tag   (fill_tag),
      .wr_line  (mmu_l1_read_data),
      .clr_en   (state_q == FLUSH),
      .clr_idx  (flush_idx_q)
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == req_tag);
  end

  // Hit detection and hit-way line selection
  logic              hit;
  logic [LINE_W-1:0] hit_line;
  logic [31:0]       hit_word;

  always_comb begin
    hit_line = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_line = hit_line | way_line[w];
    end
    hit      = l1_read && !mmio && (|way_hit);
    hit_word = hit_line[{req_word, 5'd0} +: 32];
  end

  // Victim choice: lowest invalid way, else the set's round-robin pointer
  logic [WAY_W-1:0] victim_sel;
  logic             found;

  always_comb begin
    victim_sel = rr_q[req_idx];
    found      = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !way_valid[w]) begin
        victim_sel = WAY_W'(w);
        found      = 1'b1;
      end
    end
  end

  // Stall and fetch data; a completing MMIO bypass releases the pipe
  // in the done cycle itself, unlike a refill which hits one cycle later.
  logic bypass_done;

  always_comb begin
    bypass_done = (state_q == BYPASS) && mmu_l1_done;
    stall = ((l1_read && !(hit && state_q == IDLE)) || (state_q != IDLE))
            && !bypass_done;
    l1_data_o = '0;
    if (bypass_done) l1_data_o = mmu_l1_read_data[31:0];
    else if (hit)    l1_data_o = hit_word;
  end

  // FSM next state, MMU request and replacement update
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    victim_d    = victim_q;
    pend_d      = pend_q;
    flush_idx_d = flush_idx_q;
    req_d       = req_q;
    req_addr_d  = req_addr_q;
    rr_d        = rr_q;
    case (state_q)
      IDLE: begin
        if (pend_q || l1_invalidate) begin
          state_d     = FLUSH;
          pend_d      = 1'b0;
          flush_idx_d = '0;
        end else if (l1_read && mmio) begin
          state_d    = BYPASS;
          req_d      = 1'b1;
          req_addr_d = l1_addr;
        end else if (l1_read && !hit) begin
          state_d    = REFILL;
          req_d      = 1'b1;
          req_addr_d = {l1_addr[31:OFF_W], {OFF_W{1'b0}}};
          line_d     = l1_addr[31:OFF_W];
          victim_d   = victim_sel;
        end
      end
      REFILL: begin
        if (l1_invalidate) pend_d = 1'b1;
        if (mmu_l1_done) begin
          state_d        = IDLE;
          req_d          = 1'b0;
          rr_d[fill_idx] = (WAYS == 1) ? '0 : WAY_W'(rr_q[fill_idx] + 1'b1);
        end
      end
      BYPASS: begin
        if (l1_invalidate) pend_d = 1'b1;
        if (mmu_l1_done) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      FLUSH: begin
        flush_idx_d = IDX_W'(flush_idx_q + 1'b1);
        if (flush_idx_q == IDX_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers, asynchronously reset
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_q      <= '0;
      victim_q    <= '0;
      pend_q      <= 1'b0;
      flush_idx_q <= '0;
      req_q       <= 1'b0;
      req_addr_q  <= '0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      victim_q    <= victim_d;
      pend_q      <= pend_d;
      flush_idx_q <= flush_idx_d;
      req_q       <= req_d;
      req_addr_q  <= req_addr_d;
      rr_q        <= rr_d;
    end
  end

  assign l1_mmu_req_read = req_q;
  assign l1_mmu_req_addr = req_addr_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hits_q, perf_hits_d;
  logic [31:0] perf_misses_q, perf_misses_d;

  // Hit cycles delivered to IF, and IDLE->REFILL transitions
  always_comb begin
    perf_hits_d   = perf_hits_q + 32'(hit && !stall);
    perf_misses_d = perf_misses_q + 32'((state_q == IDLE) && (state_d == REFILL));
  end

  // Counter registers, wrap naturally
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
    end else begin
      perf_hits_q   <= perf_hits_d;
      perf_misses_q <= perf_misses_d;
    end
  end

  assign perf_hits   = perf_hits_q;
  assign perf_misses = perf_misses_q;
`endif

endmodule

// File: tb/tb_l1icache_sa.sv
// tb_l1icache_sa: directed and randomized fetch stimulus for l1icache_sa,
// checked against a set/way/valid/tag reference model with a bench-driven
// MMU. Perf-counter checks are built when ICACHE_PERF_CNT_EN is defined.
module tb_l1icache_sa;

  localparam int unsigned WAYS       = 2;
  localparam int unsigned SETS       = 256;
  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned WORDS      = LINE_BYTES / 4;

  logic                    sys_clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    l1_read = 1'b0;
  logic [31:0]             l1_addr = '0;
  logic [31:0]             l1_data_o;
  logic                    stall;
  logic                    l1_invalidate = 1'b0;
  logic                    l1_mmu_req_read;
  logic [31:0]             l1_mmu_req_addr;
  logic                    mmu_l1_done = 1'b0;
  logic [LINE_BYTES*8-1:0] mmu_l1_read_data = '0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]             perf_hits;
  logic [31:0]             perf_misses;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  int unsigned mtag [SETS][WAYS];
  bit          mval [SETS][WAYS];
  int unsigned mrr  [SETS];
  int unsigned m_hits;
  int unsigned m_misses;

  always #5 sys_clk = ~sys_clk;

  l1icache_sa #(
    .WAYS       (WAYS),
    .SETS       (SETS),
    .LINE_BYTES (LINE_BYTES),
    .MMIO_BASE  (32'hFFFF_0000),
    .MMIO_MASK  (32'hFFFF_0000)
  ) dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .l1_read          (l1_read),
    .l1_addr          (l1_addr),
    .l1_data_o        (l1_data_o),
    .stall            (stall),
    .l1_invalidate    (l1_invalidate),
    .l1_mmu_req_read  (l1_mmu_req_read),
    .l1_mmu_req_addr  (l1_mmu_req_addr),
    .mmu_l1_done      (mmu_l1_done),
    .mmu_l1_read_data (mmu_l1_read_data)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .perf_hits        (perf_hits),
    .perf_misses      (perf_misses)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge; inputs change here.
  task automatic nxt();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] wd(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_1234;
  endfunction

  function automatic logic [LINE_BYTES*8-1:0] line_of(input logic [31:0] la);
    logic [LINE_BYTES*8-1:0] l;
    for (int i = 0; i < WORDS; i++) l[32*i +: 32] = wd(la + 32'(4 * i));
    return l;
  endfunction

  function automatic bit mmio_m(input logic [31:0] a);
    return (a & 32'hFFFF_0000) == 32'hFFFF_0000;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mval[s][w] = 1'b0;
        mtag[s][w] = 0;
      end
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic m_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) mval[s][w] = 1'b0;
  endtask

  // Count FLUSH cycles from the first flush cycle onward, bounded.
  task automatic flush_wait();
    int n;
    n = 0;
    while (stall && n < SETS + 8) begin
      n++;
      nxt();
      settle();
    end
    check("flush_len", n, SETS);
    m_flush();
  endtask

  // One fetch transaction with the MMU answering lat cycles after request.
  task automatic fetch(input logic [31:0] a, input int lat, input bit inv_mid,
                       output bit was_hit);
    int unsigned s, t;
    int way, v;
    logic [31:0] rdw;
    s = (a / LINE_BYTES) % SETS;
    t = a / (LINE_BYTES * SETS);
    nxt();
    l1_read = 1'b1;
    l1_addr = a;
    settle();
    was_hit = !stall;
    if (mmio_m(a)) begin
      check("mmio_stall0", stall, 1);
      nxt();
      l1_invalidate = inv_mid;
      settle();
      check("mmio_req", l1_mmu_req_read, 1);
      check("mmio_addr", l1_mmu_req_addr, a);
      for (int k = 0; k < lat; k++) begin
        check("mmio_wait", stall, 1);
        nxt();
        l1_invalidate = 1'b0;
        settle();
      end
      rdw = $urandom;
      mmu_l1_done = 1'b1;
      mmu_l1_read_data = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, rdw};
      settle();
      check("mmio_done_stall", stall, 0);
      check("mmio_data", l1_data_o, rdw);
      nxt();
      mmu_l1_done = 1'b0;
      l1_invalidate = 1'b0;
      l1_read = 1'b0;
      settle();
      check("mmio_req_drop", l1_mmu_req_read, 0);
      if (inv_mid) begin
        nxt();
        settle();
        flush_wait();
      end
      return;
    end
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (mval[s][w] && mtag[s][w] == t) way = w;
    if (way >= 0) begin
      check("hit_stall", stall, 0);
      check("hit_data", l1_data_o, wd(a & ~32'h3));
      m_hits++;
      return;
    end
    check("miss_stall0", stall, 1);
    nxt();
    l1_invalidate = inv_mid;
    settle();
    check("refill_req", l1_mmu_req_read, 1);
    check("refill_addr", l1_mmu_req_addr, a & ~32'(LINE_BYTES - 1));
    for (int k = 0; k < lat; k++) begin
      check("refill_wait", stall, 1);
      nxt();
      l1_invalidate = 1'b0;
      settle();
    end
    check("refill_done_stall", stall, 1);
    mmu_l1_done = 1'b1;
    mmu_l1_read_data = line_of(a & ~32'(LINE_BYTES - 1));
    nxt();
    mmu_l1_done = 1'b0;
    l1_invalidate = 1'b0;
    settle();
    check("refill_req_drop", l1_mmu_req_read, 0);
    check("after_refill_stall", stall, 0);
    check("after_refill_data", l1_data_o, wd(a & ~32'h3));
    v = -1;
    for (int w = 0; w < WAYS; w++)
      if (!mval[s][w] && v < 0) v = w;
    if (v < 0) v = int'(mrr[s]);
    mrr[s] = (mrr[s] + 1) % WAYS;
    mval[s][v] = 1'b1;
    mtag[s][v] = t;
    m_misses++;
    m_hits++;
    if (inv_mid) begin
      nxt();
      l1_read = 1'b0;
      settle();
      flush_wait();
    end
  endtask

  task automatic apply_reset();
    nxt();
    rst_n = 1'b0;
    l1_read = 1'b0;
    l1_invalidate = 1'b0;
    mmu_l1_done = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
    m_reset();
    settle();
  endtask

  task automatic invalidate_now();
    nxt();
    l1_read = 1'b0;
    l1_invalidate = 1'b1;
    settle();
    check("inv_idle_stall", stall, 0);
    nxt();
    l1_invalidate = 1'b0;
    settle();
    flush_wait();
  endtask

  initial begin
    bit h;
    logic [31:0] a;
    int r;

    m_reset();
    apply_reset();

    // Reset values
    check("rst_stall", stall, 0);
    check("rst_req", l1_mmu_req_read, 0);
    check("rst_req_addr", l1_mmu_req_addr, 0);
    check("rst_data", l1_data_o, 0);
    l1_read = 1'b1;
    l1_addr = 32'h0000_0040;
    settle();
    check("rst_stall_read", stall, 1);
    l1_read = 1'b0;

    // Cold miss with 3-cycle MMU latency
    fetch(32'h0000_1004, 3, 1'b0, h);
    check("cold_was_hit", h, 0);

    // Conflict eviction in set 0
    fetch(32'h0000_0000, 1, 1'b0, h);
    fetch(32'h0000_2000, 2, 1'b0, h);
    fetch(32'h0000_4000, 0, 1'b0, h);
    check("conf_fill3_miss", h, 0);
    fetch(32'h0000_2000, 1, 1'b0, h);
    check("conf_2000_hit", h, 1);
    fetch(32'h0000_0000, 1, 1'b0, h);
    check("conf_0000_miss", h, 0);

    // MMIO bypass, repeated
    fetch(32'hFFFF_0010, 2, 1'b0, h);
    fetch(32'hFFFF_0010, 1, 1'b0, h);
    check("mmio_repeat_hit", h, 0);

    // Invalidate during a refill
    fetch(32'h0000_1004, 1, 1'b0, h);
    check("pre_inv_hit", h, 1);
    fetch(32'h0000_5008, 2, 1'b1, h);
    fetch(32'h0000_1004, 1, 1'b0, h);
    check("post_inv_miss", h, 0);

    // Reset during a refill, then a stray done
    nxt();
    l1_read = 1'b1;
    l1_addr = 32'h0000_6000;
    settle();
    check("rstmid_stall0", stall, 1);
    nxt();
    settle();
    check("rstmid_req", l1_mmu_req_read, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_req_async", l1_mmu_req_read, 0);
    check("rstmid_req_addr", l1_mmu_req_addr, 0);
    check("rstmid_stall", stall, 1);
    m_reset();
    nxt();
    l1_read = 1'b0;
    nxt();
    rst_n = 1'b1;
    settle();
    nxt();
    mmu_l1_done = 1'b1;
    settle();
    nxt();
    mmu_l1_done = 1'b0;
    settle();
    check("stray_done_req", l1_mmu_req_read, 0);
    check("stray_done_stall", stall, 0);
    fetch(32'h0000_6000, 2, 1'b0, h);
    check("post_rst_miss", h, 0);

`ifdef ICACHE_PERF_CNT_EN
    // 3 misses (each followed by a hit cycle) plus 7 hits
    apply_reset();
    fetch(32'h0000_0100, 1, 1'b0, h);
    fetch(32'h0000_0200, 1, 1'b0, h);
    fetch(32'h0000_0300, 1, 1'b0, h);
    for (int i = 0; i < 7; i++) fetch(32'h0000_0100 + 32'((i % 3) * 256), 0, 1'b0, h);
    nxt();
    settle();
    check("perf_hits10", perf_hits, 10);
    check("perf_misses3", perf_misses, 3);
`endif

    // Randomized traffic over a few conflicting sets plus MMIO
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12) a = 32'hFFFF_0000 + 32'($urandom_range(0, 255) * 4);
      else if (r < 15) a = 32'hFFFE_FFFC;
      else a = 32'($urandom_range(0, 4) * 8192 + $urandom_range(0, 2) * 32 +
                   $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      if (r == 99) invalidate_now();
      fetch(a, int'($urandom_range(0, 4)), ($urandom_range(0, 59) == 0), h);
      if ($urandom_range(0, 3) == 0) begin
        nxt();
        l1_read = 1'b0;
        settle();
      end
    end

`ifdef ICACHE_PERF_CNT_EN
    nxt();
    l1_read = 1'b0;
    settle();
    check("perf_hits_rand", perf_hits, m_hits);
    check("perf_misses_rand", perf_misses, m_misses);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
